mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_mux.sv | 44 ++++
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and line-transfer constants for the icache/dcache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned MEM_ADDR_BITS = 28;
    localparam int unsigned BEATS         = 4;
    localparam int unsigned BEAT_CNT_W    = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD,
        WR
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_mux.sv
// Owner-select mux for the address and write-data channels of the two cache clients.
module mem_arb_mux
    import mem_arb_pkg::*;
(
    input  arb_owner_t                 owner,
    input  logic                       ic_req_valid,
    input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
    input  logic                       ic_req_rw,
    input  logic                       ic_req_data_valid,
    input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
    input  logic                       dc_req_valid,
    input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
    input  logic                       dc_req_rw,
    input  logic                       dc_req_data_valid,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                       sel_valid,
    output logic [MEM_ADDR_BITS-1:0]   sel_addr,
    output logic                       sel_rw,
    output logic                       sel_data_valid,
    output logic [MEM_DATA_BITS-1:0]   sel_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] sel_data_mask
);

    always_comb begin
        if (owner == OWN_DC) begin
            sel_valid      = dc_req_valid;
            sel_addr       = dc_req_addr;
            sel_rw         = dc_req_rw;
            sel_data_valid = dc_req_data_valid;
            sel_data_bits  = dc_req_data_bits;
            sel_data_mask  = dc_req_data_mask;
        end else begin
            sel_valid      = ic_req_valid;
            sel_addr       = ic_req_addr;
            sel_rw         = ic_req_rw;
            sel_data_valid = ic_req_data_valid;
            sel_data_bits  = ic_req_data_bits;
            sel_data_mask  = ic_req_data_mask;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges icache and dcache line transfers onto one DRAM port; one owner per transaction.
// Define ARB_ROUND_ROBIN_EN to alternate grants on collisions (default: DC beats IC).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ic_req_valid,
    output logic                       ic_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
    input  logic                       ic_req_rw,
    input  logic                       ic_req_data_valid,
    output logic                       ic_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                       ic_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
    input  logic                       dc_req_valid,
    output logic                       dc_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
    input  logic                       dc_req_rw,
    input  logic                       dc_req_data_valid,
    output logic                       dc_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                       dc_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam logic [BEAT_CNT_W-1:0] CNT_FULL = BEAT_CNT_W'(BEATS);
    localparam logic [BEAT_CNT_W-1:0] CNT_LAST = BEAT_CNT_W'(BEATS - 1);

    arb_state_t state, state_next;
    arb_owner_t owner, owner_next, grant;
    logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_next;
    logic addr_done, addr_done_next;
`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t rr_last, rr_last_next;
`endif

    logic                       sel_valid;
    logic [MEM_ADDR_BITS-1:0]   sel_addr;
    logic                       sel_rw;
    logic                       sel_data_valid;
    logic [MEM_DATA_BITS-1:0]   sel_data_bits;
    logic [MEM_DATA_BITS/8-1:0] sel_data_mask;

    logic data_pass, data_open, data_fire, addr_fire;
    logic own_req_ready, own_data_ready, own_resp_valid;

    mem_arb_mux u_mux (
        .owner             (owner),
        .ic_req_valid      (ic_req_valid),
        .ic_req_addr       (ic_req_addr),
        .ic_req_rw         (ic_req_rw),
        .ic_req_data_valid (ic_req_data_valid),
        .ic_req_data_bits  (ic_req_data_bits),
        .ic_req_data_mask  (ic_req_data_mask),
        .dc_req_valid      (dc_req_valid),
        .dc_req_addr       (dc_req_addr),
        .dc_req_rw         (dc_req_rw),
        .dc_req_data_valid (dc_req_data_valid),
        .dc_req_data_bits  (dc_req_data_bits),
        .dc_req_data_mask  (dc_req_data_mask),
        .sel_valid         (sel_valid),
        .sel_addr          (sel_addr),
        .sel_rw            (sel_rw),
        .sel_data_valid    (sel_data_valid),
        .sel_data_bits     (sel_data_bits),
        .sel_data_mask     (sel_data_mask)
    );

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant = (dc_req_valid && (!ic_req_valid || rr_last == OWN_IC)) ? OWN_DC : OWN_IC;
`else
        grant = dc_req_valid ? OWN_DC : OWN_IC;
`endif
    end

    // Write data may stream while the address is still pending; the counter caps acceptance.
    assign data_pass = (state == WR) || ((state == REQ) && sel_rw);
    assign data_open = data_pass && (beat_cnt < CNT_FULL);
    assign data_fire = data_open && sel_data_valid && mem_req_data_ready;
    assign addr_fire = (state == REQ) && !addr_done && sel_valid && mem_req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= OWN_DC;
            beat_cnt  <= '0;
            addr_done <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last   <= OWN_IC;
`endif
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            beat_cnt  <= beat_cnt_next;
            addr_done <= addr_done_next;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last   <= rr_last_next;
`endif
        end
    end

    always_comb begin
        state_next         = state;
        owner_next         = owner;
        beat_cnt_next      = beat_cnt;
        addr_done_next     = addr_done;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_next       = rr_last;
`endif
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        own_req_ready      = 1'b0;
        own_data_ready     = 1'b0;
        own_resp_valid     = 1'b0;

        if (state != IDLE) begin
            mem_req_addr = sel_addr;
            mem_req_rw   = sel_rw;
        end
        if (data_pass) begin
            mem_req_data_bits = sel_data_bits;
            mem_req_data_mask = sel_data_mask;
        end
        if (data_open) begin
            mem_req_data_valid = sel_data_valid;
            own_data_ready     = mem_req_data_ready;
        end

        case (state)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    state_next     = REQ;
                    owner_next     = grant;
                    beat_cnt_next  = '0;
                    addr_done_next = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_next   = grant;
`endif
                end
            end
            REQ: begin
                mem_req_valid = sel_valid && !addr_done;
                own_req_ready = mem_req_ready && !addr_done;
                beat_cnt_next = beat_cnt + BEAT_CNT_W'(data_fire);
                if (addr_fire) begin
                    if (!sel_rw) begin
                        state_next = RD;
                    end else if (beat_cnt_next == CNT_FULL) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        state_next     = WR;
                        addr_done_next = 1'b1;
                    end
                end
            end
            RD: begin
                own_resp_valid = mem_resp_valid;
                if (mem_resp_valid) begin
                    if (beat_cnt == CNT_LAST) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            WR: begin
                if (data_fire) begin
                    if (beat_cnt == CNT_LAST) begin
                        state_next     = IDLE;
                        beat_cnt_next  = '0;
                        addr_done_next = 1'b0;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ic_req_ready      = own_req_ready  && (owner == OWN_IC);
    assign dc_req_ready      = own_req_ready  && (owner == OWN_DC);
    assign ic_req_data_ready = own_data_ready && (owner == OWN_IC);
    assign dc_req_data_ready = own_data_ready && (owner == OWN_DC);
    assign ic_resp_valid     = own_resp_valid && (owner == OWN_IC);
    assign dc_resp_valid     = own_resp_valid && (owner == OWN_DC);
    assign ic_resp_data      = (state == RD) ? mem_resp_data : '0;
    assign dc_resp_data      = (state == RD) ? mem_resp_data : '0;

endmodule
